// File: rtl/sm_pulse_gen.sv
// ---------------------------------------------------------------------------
// sm_pulse_gen
// Step-pulse generator for one stepper-motor driver channel, controlled
// through an Avalon-MM slave. Modes: idle, continuous run, run for NUM
// pulses, and auto (period from n_period, gated by drv_en).
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   avs_address       Avalon word address
//   avs_write         write strobe, avs_writedata carries the data
//   avs_read          read strobe, avs_readdata valid one cycle later
//   n_period          external period used in AUTO mode
//   drv_en            external enable used in AUTO mode
//   drv_pulse         registered step output (polarity from CFG.invert)
//   drv_dir           direction output, mirrors CFG.dir
//   busy              high whenever the FSM is not IDLE
//   irq               DONE & CFG.irq_en
//
// Register map: 0 CMD, 1 CFG, 2 PERIOD, 3 HIGH, 4 NUM, 5 STATUS, 6 COUNT.
// ---------------------------------------------------------------------------
module sm_pulse_gen #(
    parameter int CNT_W      = 16,
    parameter int ADDR_W     = 3,
    parameter int DEF_PERIOD = 2000,
    parameter int DEF_HIGH   = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic [CNT_W-1:0]  n_period,
    input  logic              drv_en,
    output logic              drv_pulse,
    output logic              drv_dir,
    output logic              busy,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RUN_N = 2'd2,
        ST_AUTO  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CFG    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_HIGH   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_NUM    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(6);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [3:0]       cfg;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] high_reg;
    logic [CNT_W-1:0] num_reg;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] p_lat;
    logic [CNT_W-1:0] h_lat;
    logic [CNT_W-1:0] count;
    logic             done;

    logic             cmd_wr;
    logic             cmd_start;
    logic             cmd_start_n;
    logic             cmd_stop;
    logic             cmd_clr;
    logic [CNT_W-1:0] p_src;
    logic [CNT_W-1:0] p_new;
    logic [CNT_W-1:0] h_new;
    logic             active;
    logic             step;
    logic             period_end;
    logic             run_n_done;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^avs_writedata[31:CNT_W];

    assign busy    = (state != ST_IDLE);
    assign irq     = done & cfg[3];
    assign drv_dir = cfg[2];

    // Command strobes only exist on the cycle a CMD write is presented.
    assign cmd_wr      = avs_write && (avs_address == A_CMD);
    assign cmd_start   = cmd_wr && avs_writedata[0];
    assign cmd_start_n = cmd_wr && avs_writedata[1];
    assign cmd_stop    = cmd_wr && avs_writedata[2];
    assign cmd_clr     = cmd_wr && avs_writedata[3];

    // Clamped period/high values that get latched at each period start.
    // At phase 0 the step is always high because the clamped high time is
    // at least one cycle, so the freshly latched values never need to be
    // consulted on that same cycle.
    always_comb begin
        p_src = (state == ST_AUTO) ? n_period : period_reg;
        p_new = (p_src < TWO) ? TWO : p_src;
        if (high_reg == '0)
            h_new = ONE;
        else if (high_reg > p_new - ONE)
            h_new = p_new - ONE;
        else
            h_new = high_reg;

        active     = (state == ST_RUN) || (state == ST_RUN_N) ||
                     ((state == ST_AUTO) && drv_en);
        step       = active && ((phase == '0) || (phase < h_lat));
        period_end = active && (phase != '0) && (phase == p_lat - ONE);
        run_n_done = (state == ST_RUN_N) && period_end && (count >= num_reg);
    end

    // Read multiplexer; the registered copy gives the one-cycle latency.
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            A_CFG:    rd_mux = {28'd0, cfg};
            A_PERIOD: rd_mux = 32'(period_reg);
            A_HIGH:   rd_mux = 32'(high_reg);
            A_NUM:    rd_mux = 32'(num_reg);
            A_STATUS: rd_mux = {28'd0, state, done, busy};
            A_COUNT:  rd_mux = 32'(count);
            default:  rd_mux = '0;
        endcase
    end

    // Registers, pulse datapath and the mode FSM. Later assignments in this
    // block override earlier ones, which is how FSM transitions reset the
    // phase counter and how a DONE set beats a coincident CLR_DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cfg          <= '0;
            period_reg   <= CNT_W'(DEF_PERIOD);
            high_reg     <= CNT_W'(DEF_HIGH);
            num_reg      <= '0;
            phase        <= '0;
            p_lat        <= TWO;
            h_lat        <= ONE;
            count        <= '0;
            done         <= 1'b0;
            drv_pulse    <= 1'b0;
            avs_readdata <= '0;
        end else begin
            if (avs_write) begin
                case (avs_address)
                    A_CFG:    cfg        <= avs_writedata[3:0];
                    A_PERIOD: period_reg <= avs_writedata[CNT_W-1:0];
                    A_HIGH:   high_reg   <= avs_writedata[CNT_W-1:0];
                    A_NUM:    num_reg    <= avs_writedata[CNT_W-1:0];
                    default:  ;
                endcase
            end

            if (avs_read)
                avs_readdata <= rd_mux;

            drv_pulse <= step ^ cfg[1];

            // Inactive (IDLE, or AUTO with drv_en low) parks the phase at 0.
            if (active) begin
                if (phase == '0) begin
                    p_lat <= p_new;
                    h_lat <= h_new;
                    if (count != CNT_MAX)
                        count <= count + ONE;
                end
                if (period_end)
                    phase <= '0;
                else
                    phase <= phase + ONE;
            end else begin
                phase <= '0;
            end

            if (cmd_clr)
                done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_stop) begin
                        state <= ST_IDLE;
                    end else if (cfg[0]) begin
                        state <= ST_AUTO;
                        count <= '0;
                    end else if (cmd_start_n) begin
                        if (num_reg != '0) begin
                            state <= ST_RUN_N;
                            count <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (cmd_start) begin
                        state <= ST_RUN;
                        count <= '0;
                    end
                end
                ST_RUN: begin
                    if (cmd_stop) begin
                        state <= ST_IDLE;
                        phase <= '0;
                    end
                end
                ST_RUN_N: begin
                    if (cmd_stop) begin
                        state <= ST_IDLE;
                        phase <= '0;
                    end else if (run_n_done) begin
                        state <= ST_IDLE;
                        phase <= '0;
                        done  <= 1'b1;
                    end
                end
                ST_AUTO: begin
                    if (cmd_stop || !cfg[0]) begin
                        state <= ST_IDLE;
                        phase <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_sm_pulse_gen
// Self-checking bench for sm_pulse_gen. A cycle-level behavioural model
// (position-in-period arithmetic) predicts every output each cycle, and
// directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_sm_pulse_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [15:0] n_period = '0;
    logic        drv_en = 1'b0;
    logic        drv_pulse;
    logic        drv_dir;
    logic        busy;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;
    bit check_en = 1'b0;

    // Behavioural model state: mode 0..3, position inside the current
    // period, the period/high values in force, and the register file.
    int          m_mode, m_pos, m_p, m_h, m_count;
    int          m_period, m_high, m_num;
    logic [3:0]  m_cfg;
    bit          m_done;
    bit          m_pulse;
    logic [31:0] m_rd;

    sm_pulse_gen #(
        .CNT_W(16), .ADDR_W(3), .DEF_PERIOD(2000), .DEF_HIGH(500)
    ) dut (
        .clk(clk), .rst(rst),
        .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .n_period(n_period), .drv_en(drv_en),
        .drv_pulse(drv_pulse), .drv_dir(drv_dir),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Avalon write: presented for exactly one cycle, returns one negedge
    // after the accepting clock edge.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
        avs_writedata = '0;
    endtask

    task automatic read_reg(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    task automatic wait_rise(input int max_cycles, output int cycles,
                             output bit timed_out);
        logic prev;
        prev      = drv_pulse;
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            cycles++;
            if (drv_pulse && !prev) begin
                timed_out = 1'b0;
                break;
            end
            prev = drv_pulse;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd1:    return {28'd0, m_cfg};
            3'd2:    return 32'(m_period);
            3'd3:    return 32'(m_high);
            3'd4:    return 32'(m_num);
            3'd5:    return 32'(m_mode * 4 + (m_done ? 2 : 0) + ((m_mode != 0) ? 1 : 0));
            3'd6:    return 32'(m_count);
            default: return 32'd0;
        endcase
    endfunction

    // One clock of the model, evaluated from the values seen at the edge.
    task automatic model_update();
        bit act, stp, fin, cw, c_start, c_startn, c_stop;
        int src;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_p = 2; m_h = 1; m_count = 0;
            m_period = 2000; m_high = 500; m_num = 0;
            m_cfg = '0; m_done = 1'b0; m_pulse = 1'b0; m_rd = '0;
            return;
        end
        if (avs_read)
            m_rd = model_read(avs_address);
        act = (m_mode == 1) || (m_mode == 2) || (m_mode == 3 && drv_en);
        if (act && m_pos == 0) begin
            src = (m_mode == 3) ? int'(n_period) : m_period;
            m_p = (src < 2) ? 2 : src;
            m_h = (m_high < 1) ? 1 : ((m_high > m_p - 1) ? m_p - 1 : m_high);
            if (m_count < 65535)
                m_count++;
        end
        stp     = act && (m_pos < m_h);
        m_pulse = stp ^ m_cfg[1];
        fin     = (m_mode == 2) && act && (m_pos == m_p - 1) && (m_count >= m_num);
        if (act) begin
            m_pos++;
            if (m_pos == m_p)
                m_pos = 0;
        end else begin
            m_pos = 0;
        end
        cw       = avs_write && (avs_address == 3'd0);
        c_start  = cw && avs_writedata[0];
        c_startn = cw && avs_writedata[1];
        c_stop   = cw && avs_writedata[2];
        if (cw && avs_writedata[3])
            m_done = 1'b0;
        case (m_mode)
            0: if (!c_stop) begin
                if (m_cfg[0]) begin
                    m_mode = 3; m_count = 0;
                end else if (c_startn) begin
                    if (m_num > 0) begin m_mode = 2; m_count = 0; end
                    else m_done = 1'b1;
                end else if (c_start) begin
                    m_mode = 1; m_count = 0;
                end
            end
            1: if (c_stop) begin m_mode = 0; m_pos = 0; end
            2: if (c_stop) begin
                m_mode = 0; m_pos = 0;
            end else if (fin) begin
                m_mode = 0; m_pos = 0; m_done = 1'b1;
            end
            default: if (c_stop || !m_cfg[0]) begin m_mode = 0; m_pos = 0; end
        endcase
        if (avs_write) begin
            case (avs_address)
                3'd1: m_cfg    = avs_writedata[3:0];
                3'd2: m_period = int'(avs_writedata[15:0]);
                3'd3: m_high   = int'(avs_writedata[15:0]);
                3'd4: m_num    = int'(avs_writedata[15:0]);
                default: ;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_update();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("drv_pulse", drv_pulse, m_pulse);
                checkOutput("busy", busy, (m_mode != 0));
                checkOutput("irq", irq, m_done && m_cfg[3]);
                checkOutput("drv_dir", drv_dir, m_cfg[2]);
                checkOutput("readdata", avs_readdata, m_rd);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        prev;
        int          k, rises, highs, c, g1, g2;
        bit          tmo;
        int          exp_rst [8] = '{0, 0, 2000, 500, 0, 0, 0, 0};

        // Reset and register defaults
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        checkOutput("rst_pulse", drv_pulse, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_irq", irq, 0);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), rd);
            checkOutput($sformatf("rst_reg%0d", i), rd, exp_rst[i]);
        end

        // Continuous run, PERIOD=10 HIGH=3, STOP after 50 cycles
        applyStimulus(3'd2, 10);
        applyStimulus(3'd3, 3);
        applyStimulus(3'd0, 32'h1);
        prev = drv_pulse; rises = 0; highs = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (drv_pulse && !prev) rises++;
            if (drv_pulse) highs++;
            prev = drv_pulse;
        end
        checkOutput("run_rises", rises, 5);
        checkOutput("run_high_cycles", highs, 15);
        applyStimulus(3'd0, 32'h4);
        checkOutput("stop_busy", busy, 0);
        @(negedge clk);
        checkOutput("stop_pulse", drv_pulse, 0);
        read_reg(3'd6, rd);
        checkOutput("run_count", rd, 5);

        // N-pulse run: NUM=4 PERIOD=8 HIGH=2 irq_en
        applyStimulus(3'd4, 4);
        applyStimulus(3'd2, 8);
        applyStimulus(3'd3, 2);
        applyStimulus(3'd1, 32'h8);
        applyStimulus(3'd0, 32'h2);
        checkOutput("runn_busy", busy, 1);
        k = 1; rises = 0; prev = drv_pulse;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
            if (drv_pulse && !prev) rises++;
            prev = drv_pulse;
        end
        checkOutput("runn_length", k - 1, 32);
        checkOutput("runn_rises", rises, 4);
        checkOutput("runn_irq", irq, 1);
        read_reg(3'd5, rd);
        checkOutput("runn_status", rd, 2);
        read_reg(3'd6, rd);
        checkOutput("runn_count", rd, 4);
        applyStimulus(3'd0, 32'h8);
        checkOutput("clr_done_irq", irq, 0);

        // START_N with NUM=0, then minimum period/high clamps
        applyStimulus(3'd4, 0);
        applyStimulus(3'd0, 32'h2);
        checkOutput("num0_irq", irq, 1);
        checkOutput("num0_busy", busy, 0);
        applyStimulus(3'd0, 32'h8);
        applyStimulus(3'd2, 1);
        applyStimulus(3'd3, 0);
        applyStimulus(3'd0, 32'h1);
        prev = drv_pulse; rises = 0; highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (drv_pulse && !prev) rises++;
            if (drv_pulse) highs++;
            prev = drv_pulse;
        end
        checkOutput("clamp_rises", rises, 10);
        checkOutput("clamp_highs", highs, 10);
        applyStimulus(3'd0, 32'h4);

        // AUTO mode: n_period=6, drv_en gating, n_period change
        applyStimulus(3'd3, 2);
        n_period = 16'd6;
        drv_en = 1'b1;
        applyStimulus(3'd1, 32'h1);
        @(negedge clk);
        checkOutput("auto_busy", busy, 1);
        read_reg(3'd5, rd);
        checkOutput("auto_status", rd, 13);
        repeat (8) @(negedge clk);
        drv_en = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("auto_held", drv_pulse, 0);
        drv_en = 1'b1;
        @(negedge clk);
        checkOutput("resume_hi0", drv_pulse, 1);
        @(negedge clk);
        checkOutput("resume_hi1", drv_pulse, 1);
        @(negedge clk);
        checkOutput("resume_lo", drv_pulse, 0);
        wait_rise(20, c, tmo);
        checkOutput("auto_rise_timeout", tmo, 0);
        repeat (2) @(negedge clk);
        n_period = 16'd12;
        wait_rise(20, c, tmo);
        g1 = c + 2;
        checkOutput("auto_gap_old", g1, 6);
        wait_rise(30, g2, tmo);
        checkOutput("auto_gap_new", g2, 12);
        applyStimulus(3'd1, 32'h0);
        drv_en = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("auto_exit_busy", busy, 0);

        // Invert and direction, START while running is ignored
        applyStimulus(3'd1, 32'h6);
        checkOutput("dir_out", drv_dir, 1);
        @(negedge clk);
        checkOutput("idle_inverted", drv_pulse, 1);
        applyStimulus(3'd2, 10);
        applyStimulus(3'd3, 3);
        applyStimulus(3'd0, 32'h1);
        repeat (25) @(negedge clk);
        applyStimulus(3'd0, 32'h1);
        read_reg(3'd6, rd);
        checkOutput("restart_count", rd, 3);
        read_reg(3'd5, rd);
        checkOutput("restart_status", rd, 5);
        applyStimulus(3'd0, 32'h4);
        @(negedge clk);
        checkOutput("stop_inv_idle", drv_pulse, 1);
        applyStimulus(3'd1, 32'h0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sm_pulse_gen.md
# sm_pulse_gen

Parametrised step-pulse generator for one stepper-motor driver channel, controlled over an Avalon-MM slave. Supports four modes:
- idle;
- continuous run until stopped;
- run for a programmed number of pulses;
- auto mode, where the period comes from an external input and is gated by an external enable.

Period, high time, pulse count, direction and polarity are all software-programmable. Status, a pulse counter and a done interrupt are readable. It sits between the Nios/Avalon interconnect and the SM driver pins.

## Interface
- CNT_W, 16, width of period/high/number/counter fields (2..31)
- ADDR_W, 3, Avalon word-address width
- DEF_PERIOD, 2000, PERIOD reset value (25 kHz at 50 MHz)
- DEF_HIGH, 500, HIGH reset value
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset rst, synchronous, active-high; clock clk
- avs_address  in  ADDR_W  word address
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, read latency 1
- n_period  in  CNT_W  external period for AUTO mode
- drv_en  in  1  external enable for AUTO mode
- drv_pulse  out  1  step output, registered
- drv_dir  out  1  direction output, equals CFG.dir
- busy  out  1  state != IDLE
- irq  out  1  DONE & CFG.irq_en

## Operation
Register map (word address):
- 0 CMD (write-only, single-cycle strobes, reads 0)
  - bit0 START: continuous run
  - bit1 START_N: N-pulse run
  - bit2 STOP
  - bit3 CLR_DONE
- 1 CFG (R/W, reset 0)
  - bit0 auto
  - bit1 invert
  - bit2 dir
  - bit3 irq_en
- 2 PERIOD (R/W, CNT_W bits, reset DEF_PERIOD)
- 3 HIGH (R/W, reset DEF_HIGH)
- 4 NUM (R/W, reset 0)
- 5 STATUS (RO)
  - bit0 busy
  - bit1 done
  - bits[3:2] state: IDLE=0, RUN=1, RUN_N=2, AUTO=3
- 6 COUNT (RO): pulses started since the last start
- 7 reads 0; writes to 5/6/7 are ignored
- Unused upper bits read 0.

State machine:
- Command priority within one write is STOP > auto > START_N > START.
- IDLE
  - CFG.auto=1 -> AUTO.
  - START -> RUN.
  - START_N with NUM>0 -> RUN_N.
  - START_N with NUM=0 -> stay IDLE, set DONE.
  - Any start clears COUNT and the phase counter.
- RUN: STOP -> IDLE.
- RUN_N
  - STOP -> IDLE; DONE is not set.
  - COUNT==NUM at the end of the last period -> IDLE, DONE=1.
- AUTO: CFG.auto=0 or STOP -> IDLE. STOP does not clear CFG.auto, so the FSM re-enters AUTO next cycle unless software clears auto.
- START/START_N while busy are ignored. CLR_DONE clears DONE; if it coincides with a DONE set, the set wins.

Pulse generation:
- A phase counter runs 0..P-1.
- step=1 while phase < H'; drv_pulse = step ^ CFG.invert.
- In IDLE, step=0 and phase=0.
- Period and high time are latched into P/H' when phase=0 (at start and at each wrap). Register or n_period changes take effect only at the next period boundary.
- Clamps:
  - P = max(period_src, 2), where period_src is PERIOD, or n_period in AUTO.
  - H' = HIGH clamped to 1..P-1.
- COUNT increments, saturating at all-ones, on each phase=0 cycle while running.
- AUTO with drv_en=0:
  - phase is held at 0, step=0, COUNT holds.
  - Running resumes from phase 0 when drv_en returns to 1.
- STOP truncates the current pulse.

## Timing
- Reset: drv_pulse=0, avs_readdata=0, busy=0, irq=0, drv_dir=0, state IDLE, COUNT=0, DONE=0.
- Write accepted at cycle t:
  - Registers update at t+1.
  - START: state=RUN and phase=0 at t+1; first step high at t+1, so drv_pulse changes at t+2 (registered output).
- STOP at t: state=IDLE at t+1; drv_pulse returns to the invert level at t+2.
- RUN_N: exactly NUM pulses, each P cycles.
  - The total run is NUM·P cycles from the first step to the IDLE transition.
  - busy falls and DONE/irq rise on the same cycle.
- Read at t: avs_readdata valid at t+1 and held until the next read.
- CFG.invert applies on the next cycle in all states, including IDLE.

## Test plan
- Reset, then read all registers -> PERIOD=2000, HIGH=500, all others 0; drv_pulse=0.
- PERIOD=10, HIGH=3, START; stop after 50 cycles -> 5 pulses, each 3 high / 7 low; COUNT=5; drv_pulse low 2 cycles after STOP.
- NUM=4, PERIOD=8, HIGH=2, irq_en=1, START_N -> exactly 4 pulses; busy falls 32 cycles after the first step; DONE=1 and irq=1; CLR_DONE drops irq.
- START_N with NUM=0 -> no pulse, DONE=1 next cycle. PERIOD=1 and HIGH=0 -> period 2, high 1.
- AUTO with n_period=6, HIGH=2; toggle drv_en low mid-period -> output held idle, resumes from phase 0. Change n_period to 12 mid-period -> takes effect at the next wrap.
- CFG invert=1 while running -> waveform inverted; idle level 1. START while RUN -> ignored; COUNT is not cleared.
